// File: rtl/pc_seq_if.sv
// Fetch-side bus of the PC sequencer: control in, PC and return-stack status out.
// The master drives stall/op/buscin; the slave (pc_seq_unit) drives the rest.
interface pc_seq_if #(
  parameter int unsigned AW        = 5,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic          stall;
  logic [2:0]    op;
  logic [AW-1:0] buscin;
  logic [AW-1:0] newadr;
  logic [CW-1:0] ras_cnt;
  logic          ras_full;
  logic          ras_empty;
  logic          trap;

  modport master (
    output stall, op, buscin,
    input  newadr, ras_cnt, ras_full, ras_empty, trap
  );

  modport slave (
    input  stall, op, buscin,
    output newadr, ras_cnt, ras_full, ras_empty, trap
  );
endinterface

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: INC/JMP/BR/CALL/RET with an internal return-address stack.
// Define PC_TRAP_EN to redirect stack overflow/underflow to TRAP_VEC with a one-cycle trap pulse.
module pc_seq_unit #(
  parameter int unsigned AW        = 5,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_VEC = 0,
  parameter int unsigned TRAP_VEC  = (2 ** AW) - 1
) (
  input logic      clk,
  input logic      reset,
  pc_seq_if.slave  bus
);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [AW-1:0] ResetPc = AW'(RESET_VEC);
  localparam logic [CW-1:0] FullCnt = CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OpInc  = 3'd0,
    OpJmp  = 3'd1,
    OpBr   = 3'd2,
    OpCall = 3'd3,
    OpRet  = 3'd4
  } op_e;

  if (RAS_DEPTH < 2 || TRAP_VEC >= (2 ** AW)) begin : g_bad_param
    $error("pc_seq_unit: RAS_DEPTH must be >= 2 and TRAP_VEC must fit in AW bits");
  end

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic          push;
  logic          fault;
  logic          full, empty;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ras_top;

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign pc_inc  = pc_q + AW'(1);
  assign ras_top = ras_q[IW'(cnt_q - CW'(1))];

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    fault = 1'b0;
    if (!bus.stall) begin
      unique case (bus.op)
        OpInc: pc_d = pc_inc;
        OpJmp: pc_d = bus.buscin;
        // Offset is AW-bit two's complement, so a plain modulo-2^AW add is exact.
        OpBr:  pc_d = pc_q + bus.buscin;
        OpCall: begin
          if (!full) begin
            push  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            pc_d  = bus.buscin;
          end else begin
            fault = 1'b1;
            pc_d  = bus.buscin;
          end
        end
        OpRet: begin
          if (!empty) begin
            cnt_d = cnt_q - CW'(1);
            pc_d  = ras_top;
          end else begin
            fault = 1'b1;
            pc_d  = pc_inc;
          end
        end
        default: pc_d = pc_q;
      endcase
`ifdef PC_TRAP_EN
      if (fault) begin
        pc_d = AW'(TRAP_VEC);
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= ResetPc;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage needs no reset: entries above cnt_q are never read.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      ras_q[IW'(cnt_q)] <= pc_inc;
    end
  end

`ifdef PC_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q <= 1'b0;
    end else begin
      trap_q <= fault;
    end
  end

  assign bus.trap = trap_q;
`else
  logic unused_fault;
  assign unused_fault = fault;
  assign bus.trap     = 1'b0;
`endif

  assign bus.newadr    = pc_q;
  assign bus.ras_cnt   = cnt_q;
  assign bus.ras_full  = full;
  assign bus.ras_empty = empty;
endmodule
